// File: rtl/meas_result_capture.sv
// meas_result_capture: waits for the measurement pipeline to settle after test end, snapshots all results.
// Define MEAS_AVG_DELAY_EN to add the serial SUM_DEL/RD_REQ divider driving avg_delay_o.
module meas_result_capture #(
  parameter int unsigned SETTLE_CYC    = 4,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            test_start_i,
  input  logic            test_finish_i,
  input  logic            meas_busy_i,
  input  logic [7:0][31:0] meas_result_i,
  output logic [7:0][31:0] snap_result_o,
  output logic [31:0]     avg_delay_o,
  output logic            snap_valid_o,
  output logic            timeout_o,
  output logic            capture_busy_o
);
  typedef enum logic [2:0] {IDLE, ARMED, DRAIN, CAPTURE, DIVIDE, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] settle_cnt, settle_nxt;
  logic [15:0] drain_cnt, drain_nxt;
  logic settled, expired, busy_nxt, valid_nxt;
`ifdef MEAS_AVG_DELAY_EN
  logic [31:0] rem, quo, quo_nxt, rem_nxt;
  logic [32:0] trial;
  logic [4:0] div_cnt;
  logic div_zero, div_last;
  assign div_zero = snap_result_o[7] == '0;
  assign div_last = div_cnt == 5'd31;
  assign trial = {rem, quo[31]} - {1'b0, snap_result_o[7]};
  assign quo_nxt = {quo[30:0], ~trial[32]};
  assign rem_nxt = trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
`endif
  assign settle_nxt = meas_busy_i ? 8'd0 : (settle_cnt == 8'hff ? settle_cnt : settle_cnt + 8'd1);
  assign drain_nxt = drain_cnt == 16'hffff ? drain_cnt : drain_cnt + 16'd1;
  assign settled = settle_nxt == 8'(SETTLE_CYC);
  assign expired = drain_nxt == 16'(DRAIN_TIMEOUT - 1);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (test_start_i) state_nxt = ARMED;
    else
      case (state)
        ARMED:   state_nxt = test_finish_i ? DRAIN : ARMED;
        DRAIN:   state_nxt = (settled || expired) ? CAPTURE : DRAIN;
`ifdef MEAS_AVG_DELAY_EN
        CAPTURE: state_nxt = DIVIDE;
        DIVIDE:  state_nxt = (div_zero || div_last) ? DONE : DIVIDE;
`else
        CAPTURE: state_nxt = DONE;
`endif
        default: state_nxt = state;
      endcase
  end
  always_comb begin
    busy_nxt = state_nxt inside {DRAIN, CAPTURE, DIVIDE};
    valid_nxt = state_nxt == DONE;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      capture_busy_o <= 1'b0;
      snap_valid_o <= 1'b0;
      timeout_o <= 1'b0;
      snap_result_o <= '0;
      settle_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      capture_busy_o <= busy_nxt;
      snap_valid_o <= valid_nxt;
      settle_cnt <= (state == DRAIN && !test_start_i) ? settle_nxt : 8'd0;
      drain_cnt <= (state == DRAIN && !test_start_i) ? drain_nxt : 16'd0;
      if (test_start_i) begin
        timeout_o <= 1'b0;
        snap_result_o <= '0;
      end else begin
        if (state == DRAIN && expired && !settled) timeout_o <= 1'b1;
        if (state == CAPTURE) snap_result_o <= meas_result_i;
      end
    end
`ifdef MEAS_AVG_DELAY_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      rem <= '0;
      quo <= '0;
      div_cnt <= '0;
      avg_delay_o <= '0;
    end else if (test_start_i) begin
      avg_delay_o <= '0;
    end else if (state == CAPTURE) begin
      rem <= '0;
      quo <= meas_result_i[6];
      div_cnt <= '0;
    end else if (state == DIVIDE) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
      div_cnt <= div_cnt + 5'd1;
      if (div_zero) avg_delay_o <= '0;
      else if (div_last) avg_delay_o <= quo_nxt;
    end
`else
  assign avg_delay_o = '0;
`endif
endmodule

// File: tb/tb_meas_result_capture.sv
// tb_meas_result_capture: table-driven and randomized runs checked against a spec-level timing/arithmetic model.
module tb_meas_result_capture;
  localparam int S = 4, DT = 17;
`ifdef MEAS_AVG_DELAY_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 0, rst_n = 1, start = 0, finish = 0, busy = 0;
  logic [7:0][31:0] res = '0, snap;
  logic [31:0] avg;
  logic valid, to, cbusy;
  int pass = 0, total = 0;
  typedef struct {
    logic [63:0] mask;
    logic [31:0] sum;
    logic [31:0] rd;
    int          cap;
    bit          to;
    logic [31:0] avg;
  } rec_t;
  rec_t tbl[6];

  meas_result_capture #(.SETTLE_CYC(S), .DRAIN_TIMEOUT(DT)) dut (
    .clk_i(clk), .rst_i(rst_n), .test_start_i(start), .test_finish_i(finish),
    .meas_busy_i(busy), .meas_result_i(res), .snap_result_o(snap), .avg_delay_o(avg),
    .snap_valid_o(valid), .timeout_o(to), .capture_busy_o(cbusy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0][31:0] rnd_res(input logic [31:0] sum, input logic [31:0] rd);
    logic [7:0][31:0] r;
    for (int i = 0; i < 6; i++) r[i] = $urandom;
    r[6] = sum;
    r[7] = rd;
    return r;
  endfunction

  // CAPTURE cycle offset from test_finish: first cycle after S idle DRAIN cycles, else the timeout.
  function automatic int model_cap(input logic [63:0] m, output bit tmo);
    int run = 0;
    tmo = 0;
    for (int k = 1; k < 200; k++) begin
      run = (k < 64 && m[k]) ? 0 : run + 1;
      if (run == S) return k + 1;
      if (k == DT - 1) begin
        tmo = 1;
        return k + 1;
      end
    end
    return -1;
  endfunction

  task automatic run(input rec_t r, input bit collide, input string tag);
    logic [7:0][31:0] hist[80];
    int vk = -1, nb = 0, exp_v;
    res = rnd_res(r.sum, r.rd);
    if (collide) begin
      start = 1; finish = 1; step(); start = 0; finish = 0;
      chk({tag, "/coll_valid"}, valid, 0);
      chk({tag, "/coll_busy"}, cbusy, 0);
      chk({tag, "/coll_snap"}, snap, 0);
      step();
      chk({tag, "/coll_nodrain"}, cbusy, 0);
    end else begin
      start = 1; step(); start = 0;
      chk({tag, "/start_valid"}, valid, 0);
      chk({tag, "/start_avg"}, avg, 0);
    end
    finish = 1; step(); finish = 0;
    for (int k = 1; k < 80; k++) begin
      busy = (k < 64) ? r.mask[k] : 1'b0;
      res = rnd_res(r.sum, r.rd);
      hist[k] = res;
      if (cbusy) nb++;
      if (valid && vk < 0) vk = k;
      step();
      if (vk > 0 && k >= vk + 3) break;
    end
    busy = 0;
    exp_v = r.cap + (EN ? (r.rd == 0 ? 2 : 33) : 1);
    chk({tag, "/valid_cycle"}, vk, exp_v);
    chk({tag, "/busy_cycles"}, nb, exp_v - 1);
    chk({tag, "/timeout"}, to, r.to);
    chk({tag, "/avg"}, avg, EN ? r.avg : 32'd0);
    if (r.cap > 0 && r.cap < 80) chk({tag, "/snap"}, snap, hist[r.cap]);
  endtask

  initial begin
    int bad;
    rec_t rr;
    tbl[0] = '{64'h0, 32'd1000, 32'd7, 5, 1'b0, 32'd142};
    tbl[1] = '{64'h17FE, 32'd999, 32'd3, 17, 1'b0, 32'd333};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'd50, 32'd8, DT, 1'b1, 32'd6};
    tbl[3] = '{64'h0, 32'd5, 32'd0, 5, 1'b0, 32'd0};
    tbl[4] = '{64'h2, 32'hFFFF_FFFF, 32'd1, 6, 1'b0, 32'hFFFF_FFFF};
    tbl[5] = '{64'h0, 32'd6, 32'hFFFF_FFFF, 5, 1'b0, 32'd0};
    #2 rst_n = 0;
    step(); step();
    chk("rst/valid", valid, 0);
    chk("rst/timeout", to, 0);
    chk("rst/busy", cbusy, 0);
    chk("rst/avg", avg, 0);
    chk("rst/snap", snap, 0);
    rst_n = 1;
    step();
    for (int i = 0; i < 6; i++) run(tbl[i], 1'b0, $sformatf("tbl%0d", i));
    run(tbl[0], 1'b1, "collide");
    for (int i = 0; i < 24; i++) begin
      rr.mask = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      for (int b = 1; b < 20; b++) if ($urandom_range(0, 2) == 0) rr.mask[b] = 1'b1;
      rr.sum = $urandom;
      rr.rd = ($urandom_range(0, 3) == 0) ? 32'd0 : (i[0] ? $urandom : $urandom_range(1, 1000));
      rr.cap = model_cap(rr.mask, rr.to);
      rr.avg = (rr.rd == 0) ? 32'd0 : rr.sum / rr.rd;
      run(rr, 1'b0, $sformatf("rnd%0d", i));
    end
    res = rnd_res(32'd1000, 32'd7);
    start = 1; step(); start = 0;
    finish = 1; step(); finish = 0;
    repeat (S + 3) step();
    #2 rst_n = 0;
    #1;
    chk("rstmid/valid", valid, 0);
    chk("rstmid/timeout", to, 0);
    chk("rstmid/busy", cbusy, 0);
    chk("rstmid/avg", avg, 0);
    chk("rstmid/snap", snap, 0);
    @(posedge clk); #1 rst_n = 1;
    finish = 1; step(); finish = 0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid || cbusy) bad++;
      step();
    end
    chk("rstmid/idle_after", bad, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/meas_result_capture.md
Name: meas_result_capture

Overview:
- Sits directly downstream of the measurement block, between its result vector and the CSR block.
- After the traffic generator reports test end, it waits for the measurement pipeline to drain and settle.
- It then takes one coherent snapshot of all eight 32-bit result words and computes average read delay per request (sum_delay / rd_req).
- The CSR block reads only the snapshot, never the live counters.

Parameters:
- SETTLE_CYC, 4: consecutive cycles meas_busy_i must be low before capture; legal range 1..255.
- DRAIN_TIMEOUT, 1024: maximum DRAIN-state cycles before a forced capture; legal range 2..65535.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-low reset
- test_start_i  input  1  one-cycle pulse from CSR block; arms a new test
- test_finish_i  input  1  one-cycle pulse from traffic generator; last transaction issued
- meas_busy_i  input  1  measurement block busy (pending reads or write sum pipeline)
- meas_result_i  input  8x32  live results; index 0..7 = WR_TICKS, WR_UNITS, RD_TICKS, RD_WORDS, MIN_DEL, MAX_DEL, SUM_DEL, RD_REQ
- snap_result_o  output  8x32  captured results, same index order
- avg_delay_o  output  32  floor(SUM_DEL / RD_REQ) of the snapshot
- snap_valid_o  output  1  snapshot and average valid
- timeout_o  output  1  capture was forced by DRAIN_TIMEOUT
- capture_busy_o  output  1  block is in DRAIN, CAPTURE or DIVIDE

Behaviour:
- Reset (rst_i low, async): state IDLE; snap_result_o all 0; avg_delay_o 0; snap_valid_o 0; timeout_o 0; capture_busy_o 0; internal counters 0.
- States: IDLE, ARMED, DRAIN, CAPTURE, DIVIDE, DONE.
- test_start_i from any state goes to ARMED next cycle. It clears snap_valid_o, timeout_o, snap_result_o and avg_delay_o, and aborts any drain or divide in progress.
- test_start_i has priority over test_finish_i in the same cycle.
- ARMED: test_finish_i goes to DRAIN. settle_cnt and drain_cnt load 0.
- test_finish_i outside ARMED is ignored.
- DRAIN, each cycle:
  - drain_cnt increments.
  - settle_cnt increments if meas_busy_i is 0; otherwise it clears to 0.
  - settle_cnt reaching SETTLE_CYC goes to CAPTURE.
  - Otherwise, drain_cnt reaching DRAIN_TIMEOUT-1 sets timeout_o and goes to CAPTURE.
  - If both conditions hold in the same cycle, settle wins and timeout_o stays 0.
- CAPTURE: one cycle. All 8 words of meas_result_i are registered into snap_result_o in that cycle. Goes to DIVIDE.
- DIVIDE: radix-2 restoring divider, unsigned 32/32, quotient truncated.
  - Dividend = captured SUM_DEL; divisor = captured RD_REQ.
  - Divisor 0: one DIVIDE cycle, avg_delay_o = 0, then DONE.
  - Otherwise exactly 32 DIVIDE cycles, then avg_delay_o is loaded and the state goes to DONE.
  - avg_delay_o holds its old value (0 after start) until then.
- DONE: snap_valid_o = 1. Holds until test_start_i or reset.
- Latency, with test_finish_i at cycle T and meas_busy_i low throughout:
  - DRAIN in T+1..T+SETTLE_CYC; CAPTURE at T+SETTLE_CYC+1.
  - snap_valid_o high at T+SETTLE_CYC+34.
  - With zero divisor: snap_valid_o high at T+SETTLE_CYC+3.
- capture_busy_o is a registered state decode, high exactly while the state is DRAIN, CAPTURE or DIVIDE.
- Counter widths: settle_cnt 8 bits, drain_cnt 16 bits. Both saturate and never wrap.
- meas_result_i is sampled only in CAPTURE. snap_result_o never changes in DONE.

Optional Feature:
- Macro MEAS_AVG_DELAY_EN.
- Defined: divider and DIVIDE state present, behaviour exactly as above.
- Undefined:
  - No divider logic; avg_delay_o tied to 0.
  - CAPTURE goes directly to DONE.
  - snap_valid_o high at T+SETTLE_CYC+2.

Test Plan:
- Reset mid-DIVIDE: assert rst_i low for 1 cycle -> all outputs 0 immediately (async), state IDLE, no snap_valid_o afterwards.
- Nominal run (SETTLE_CYC=4): start, finish at T, busy 0, SUM_DEL=1000, RD_REQ=7 -> snap_valid_o at T+38, avg_delay_o=142, timeout_o=0, snap_result_o equals meas_result_i sampled at T+5.
- Busy glitch: busy high at T+1..T+10, low at T+11, high at T+12, low from T+13 -> capture at T+17; results changed at T+15 are captured.
- Timeout: DRAIN_TIMEOUT=16, busy held high -> timeout_o=1, CAPTURE at T+16, snap_valid_o at T+49.
- Zero divisor: RD_REQ=0, SUM_DEL=5 -> avg_delay_o=0, snap_valid_o at T+SETTLE_CYC+3.
- Start vs finish collision: test_start_i and test_finish_i both high in DONE -> ARMED, snap_valid_o=0, no drain. A second finish two cycles later -> normal capture.
